// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side prediction and execute-side resolution signals that
// pass between the core pipeline and the branch predictor.
//   master : core side (drives PCF and the execute-stage resolution inputs)
//   slave  : predictor side (drives prediction, resolve status, redirect PC)
// Optional macro BP_PERF_COUNTERS_EN adds branchCount / mispredictCount.
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PCF;
  logic                  predictTakenF;
  logic [ADDR_WIDTH-1:0] predictTargetF;
  logic                  btbHitF;
  logic                  resolveE;
  logic [ADDR_WIDTH-1:0] PCE;
  logic                  takenE;
  logic [ADDR_WIDTH-1:0] targetE;
  logic                  predictedTakenE;
  logic [ADDR_WIDTH-1:0] predictedTargetE;
  logic                  branch;
  logic                  branchResolved;
  logic [ADDR_WIDTH-1:0] correctPCE;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0]           branchCount;
  logic [31:0]           mispredictCount;

  modport master (
    output PCF, resolveE, PCE, takenE, targetE, predictedTakenE, predictedTargetE,
    input  predictTakenF, predictTargetF, btbHitF, branch, branchResolved, correctPCE,
    input  branchCount, mispredictCount
  );
  modport slave (
    input  PCF, resolveE, PCE, takenE, targetE, predictedTakenE, predictedTargetE,
    output predictTakenF, predictTargetF, btbHitF, branch, branchResolved, correctPCE,
    output branchCount, mispredictCount
  );
`else
  modport master (
    output PCF, resolveE, PCE, takenE, targetE, predictedTakenE, predictedTargetE,
    input  predictTakenF, predictTargetF, btbHitF, branch, branchResolved, correctPCE
  );
  modport slave (
    input  PCF, resolveE, PCE, takenE, targetE, predictedTakenE, predictedTargetE,
    output predictTakenF, predictTargetF, btbHitF, branch, branchResolved, correctPCE
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped 2-bit saturating counter table plus BTB for the RV32I front
// end. Prediction is combinational from PCF; resolution in execute is
// combinational and the table update happens on the edge ending a resolveE
// cycle (no bypass to a same-cycle fetch).
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset; clears all tables immediately
//   bp   - branch_predictor_if.slave: PCF in / predictTakenF, predictTargetF,
//          btbHitF out; resolveE, PCE, takenE, targetE, predictedTakenE,
//          predictedTargetE in / branch, branchResolved, correctPCE out
// Optional macro BP_PERF_COUNTERS_EN: adds saturating 32-bit branchCount and
// mispredictCount on the interface.
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  logic [1:0]            r_ctr    [ENTRIES];
  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

  logic [IDX-1:0]   w_idxF, w_idxE;
  logic [TAG_W-1:0] w_tagF, w_tagE;
  logic             w_hitF, w_hitE, w_mispredict;
  logic             w_unused;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign w_idxF = bp.PCF[IDX+1:2];
  assign w_tagF = bp.PCF[ADDR_WIDTH-1:IDX+2];
  assign w_idxE = bp.PCE[IDX+1:2];
  assign w_tagE = bp.PCE[ADDR_WIDTH-1:IDX+2];
  // Instruction-alignment bits carry no index/tag information.
  assign w_unused = ^{bp.PCF[1:0], bp.PCE[1:0]};

  // Fetch-side lookup
  assign w_hitF            = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
  assign bp.btbHitF        = w_hitF;
  assign bp.predictTakenF  = w_hitF && r_ctr[w_idxF][1];
  assign bp.predictTargetF = w_hitF ? r_target[w_idxF] : '0;

  // Execute-side resolution; a correctly predicted not-taken branch ignores
  // the carried target since nothing was redirected.
  assign w_mispredict = bp.resolveE &&
                        ((bp.predictedTakenE != bp.takenE) ||
                         (bp.takenE && bp.predictedTakenE &&
                          (bp.predictedTargetE != bp.targetE)));
  assign bp.branch         = bp.resolveE;
  assign bp.branchResolved = !w_mispredict;
  assign bp.correctPCE     = bp.takenE ? bp.targetE : bp.PCE + ADDR_WIDTH'(4);

  // An invalid entry counts as a miss, so a first taken branch installs at 10.
  assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i]    <= 2'b01;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (bp.resolveE) begin
      if (bp.takenE) begin
        r_ctr[w_idxE]    <= w_hitE ? sat_inc(r_ctr[w_idxE]) : 2'b10;
        r_valid[w_idxE]  <= 1'b1;
        r_tag[w_idxE]    <= w_tagE;
        r_target[w_idxE] <= bp.targetE;
      end else begin
        r_ctr[w_idxE]    <= sat_dec(r_ctr[w_idxE]);
      end
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] r_branchCount, r_mispredictCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else begin
      if (bp.resolveE && (r_branchCount != 32'hFFFF_FFFF))
        r_branchCount <= r_branchCount + 32'd1;
      if (w_mispredict && (r_mispredictCount != 32'hFFFF_FFFF))
        r_mispredictCount <= r_mispredictCount + 32'd1;
    end
  end

  assign bp.branchCount     = r_branchCount;
  assign bp.mispredictCount = r_mispredictCount;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV32I core. Provides a same-cycle taken/target prediction to the fetch stage from a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB). Resolves the prediction in execute against the actual outcome and drives `branch` and `branchResolved`, which the hazard unit consumes to decide the front-end flush. Also supplies the corrected PC for redirect.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; power of two, ≥2.
- `ADDR_WIDTH`, 32: PC width.

Ports:
- `clk`  in  1  core clock; all updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PCF`  in  ADDR_WIDTH  fetch-stage PC.
- `predictTakenF`  out  1  predict taken for `PCF`.
- `predictTargetF`  out  ADDR_WIDTH  predicted target for `PCF`; 0 when `btbHitF`=0.
- `btbHitF`  out  1  BTB valid entry with matching tag at `PCF`.
- `resolveE`  in  1  a conditional branch or jal is valid in execute this cycle.
- `PCE`  in  ADDR_WIDTH  PC of the instruction in execute.
- `takenE`  in  1  actual outcome.
- `targetE`  in  ADDR_WIDTH  actual target.
- `predictedTakenE`  in  1  `predictTakenF` carried down the pipeline.
- `predictedTargetE`  in  ADDR_WIDTH  `predictTargetF` carried down the pipeline.
- `branch`  out  1  equals `resolveE`.
- `branchResolved`  out  1  prediction correct; 1 whenever `resolveE`=0.
- `correctPCE`  out  ADDR_WIDTH  redirect PC: `takenE` ? `targetE` : `PCE`+4.

## Operation
- Index = PC[IDX+1:2], IDX = log2(ENTRIES). Tag = PC[ADDR_WIDTH-1:IDX+2].
- Per entry: 2-bit counter `ctr`, BTB `valid`, `tag`, `target`.
- Fetch (combinational): `btbHitF` = valid[idx] && tag[idx]==tag(PCF); `predictTakenF` = btbHitF && ctr[idx][1]; `predictTargetF` = btbHitF ? target[idx] : 0.
- Resolve (combinational): mispredict = resolveE && ((predictedTakenE != takenE) || (takenE && predictedTakenE && predictedTargetE != targetE)). `branchResolved` = !mispredict.
- Update (clocked, only when `resolveE`=1, at index of `PCE`):
  - takenE=1: ctr saturating increment (11 stays 11); valid←1, tag←tag(PCE), target←targetE.
  - takenE=0: ctr saturating decrement (00 stays 00); BTB entry untouched.
  - On tag mismatch with takenE=1, entry is replaced and ctr set to 10 (weakly taken) instead of incremented.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- `PCE`+4 is modulo 2^ADDR_WIDTH (wraps at top of address space).
- The core guarantees `resolveE` is asserted for exactly one cycle per branch; a stalled or flushed execute slot presents `resolveE`=0.

## Timing
- Reset (async, immediate): all ctr←01, all valid←0, tags/targets←0. Hence `predictTakenF`=0, `btbHitF`=0, `predictTargetF`=0; `branch`=0, `branchResolved`=1, `correctPCE`=PCE+4 while `resolveE`=0.
- Prediction latency: 0 cycles (combinational from `PCF`).
- Update latency: entry written at the edge ending the `resolveE` cycle; visible to `PCF` from the next cycle.
- Same-cycle fetch and update to the same index: fetch sees the pre-update value; no bypass.
- `rst` asserted mid-operation: tables cleared immediately; pending update in that cycle is discarded.

## Configuration
- `BP_PERF_COUNTERS_EN` defined: adds outputs `branchCount` and `mispredictCount` (32-bit each), incremented on every `resolveE` cycle and every mispredict respectively, saturating at 0xFFFFFFFF, cleared by `rst`.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Post-reset: `PCF`=0x100 -> `predictTakenF`=0, `btbHitF`=0, `predictTargetF`=0; `branchResolved`=1.
- Resolve `PCE`=0x100, `takenE`=1, `targetE`=0x140 once -> next cycle `PCF`=0x100 gives `btbHitF`=1, `predictTakenF`=1 (ctr 10), `predictTargetF`=0x140.
- Mispredict: `resolveE`=1, `predictedTakenE`=0, `takenE`=1, `targetE`=0x80 -> `branch`=1, `branchResolved`=0, `correctPCE`=0x80; and `predictedTakenE`=1, `takenE`=0, `PCE`=0x200 -> `correctPCE`=0x204.
- Saturation/hysteresis: 5 taken resolutions at 0x100 -> ctr 11; one not-taken -> ctr 10, still predicts taken; two more not-taken -> ctr 00, predicts not taken.
- Aliasing (ENTRIES=16): train 0x100 taken, then `PCF`=0x140 (same index, different tag) -> `btbHitF`=0; taken resolve at 0x140 replaces entry, then `PCF`=0x100 -> `btbHitF`=0.
- Reset mid-stream with `resolveE`=1 -> no update; tables return to reset state; with `BP_PERF_COUNTERS_EN`, both counts read 0.
